// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the sequential fetch PC, issues one
// outstanding word read at a time to instruction memory, buffers returned
// instructions with their PCs and hands them to decode over valid/ready.
// A redirect flushes the queue and restarts fetch at the new target.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   redirect, redirect_pc restart request from pc_logic (low two bits dropped)
//   imem_req, imem_addr   read request / word address (held until imem_ack)
//   imem_ack, imem_rdata  transfer completion and instruction data
//   inst_valid, inst_out, inst_pc, inst_ready   decode-side handshake
module ifetch_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   pend_pc, pend_pc_next;
  logic [CW-1:0] count, count_next;
  logic [AW-1:0] head, tail;
  entry_t        queue_mem [DEPTH];

  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] redirect_tgt;
  logic        unused_lsbs;

  // Redirect targets are word aligned; the dropped bits carry no meaning.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign unused_lsbs  = ^redirect_pc[1:0];

  // Outputs decoded from registered state only.
  assign imem_req   = (state == FETCH) || (state == DRAIN);
  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_out   = queue_mem[head].inst;
  assign inst_pc    = queue_mem[head].pc;

  // Only a completed fetch in FETCH without a competing redirect is kept.
  assign push  = (state == FETCH) && imem_ack && !redirect;
  assign pop   = inst_valid && inst_ready;
  assign flush = redirect;

  assign count_next = flush ? '0 : CW'(count + CW'(push) - CW'(pop));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and fetch address selection.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    pend_pc_next  = pend_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_tgt;
          state_next    = FETCH;
        end else if (count_next < DEPTH_C) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect && imem_ack) begin
          fetch_pc_next = redirect_tgt;
        end else if (redirect) begin
          // Old request must still complete before the new one can issue.
          pend_pc_next = redirect_tgt;
          state_next   = DRAIN;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          if (count_next >= DEPTH_C) state_next = IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          fetch_pc_next = redirect ? redirect_tgt : pend_pc;
          state_next    = FETCH;
        end else if (redirect) begin
          pend_pc_next = redirect_tgt;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch PC, pending target and queue bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      pend_pc  <= pend_pc_next;
      count    <= count_next;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= AW'(tail + 1'b1);
        if (pop)  head <= AW'(head + 1'b1);
      end
    end
  end

  // Queue storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) queue_mem[tail] <= '{pc: fetch_pc, inst: imem_rdata};
  end

endmodule
